// File: rtl/coffee_pkg.sv
// Brewer state codes shared by the brewer FSM and the order scheduler,
// plus the scheduler's own state encoding.
package coffee_pkg;

    localparam logic [3:0] IDLE       = 4'd1;
    localparam logic [3:0] LIGAR      = 4'd2;
    localparam logic [3:0] VERIF_AGUA = 4'd3;
    localparam logic [3:0] ENCHER     = 4'd4;
    localparam logic [3:0] MOER       = 4'd5;
    localparam logic [3:0] FILTRO     = 4'd6;
    localparam logic [3:0] AGITADOR   = 4'd7;
    localparam logic [3:0] TAMPEAR    = 4'd8;
    localparam logic [3:0] EXTRACAO   = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4
    } sched_state_t;

endpackage

// File: rtl/cafe_order_scheduler_if.sv
// Order-side and brewer-side signals of the cafe order scheduler.
// master drives requests and the brewer state; slave is the scheduler.
interface cafe_order_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] done;
    logic             brew_start;
    logic [3:0]       brew_state;
    logic             busy;
    logic             error;
    logic [CNT_W-1:0] cups_served;

    modport master (
        output req, brew_state,
        input  grant, done, brew_start, busy, error, cups_served
    );

    modport slave (
        input  req, brew_state,
        output grant, done, brew_start, busy, error, cups_served
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
// The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_k;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_k = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (i_req[w_k]) begin
                o_idx   = w_k;
                o_valid = 1'b1;
            end
        end
        if (o_valid) o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/cafe_order_scheduler.sv
// Shares one brewer FSM among N_REQ order sources: round-robin grant, start pulse,
// follows the brewer's state codes to completion, and flags hangs with watchdogs.
module cafe_order_scheduler
    import coffee_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 8,
    parameter int BREW_TIMEOUT  = 64,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cafe_order_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMAX  = (START_TIMEOUT > BREW_TIMEOUT) ? START_TIMEOUT : BREW_TIMEOUT;
    localparam int TMR_W = $clog2(TMAX + 1);

    sched_state_t     r_state, w_next;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [TMR_W-1:0] r_timer;
    logic             r_saw_extr;
    logic             r_error;
    logic [CNT_W-1:0] r_cups;

    logic [N_REQ-1:0] w_arb_grant;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic [IDX_W-1:0] w_next_ptr;

    logic w_accept, w_ld_start, w_ld_brew, w_tick;
    logic w_set_err, w_set_saw, w_release, w_serve;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_next_ptr = (r_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : r_grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_ld_start     = 1'b0;
        w_ld_brew      = 1'b0;
        w_tick         = 1'b0;
        w_set_err      = 1'b0;
        w_set_saw      = 1'b0;
        w_release      = 1'b0;
        w_serve        = 1'b0;
        bus.brew_start = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        bus.done       = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_arb_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START: begin
                bus.brew_start = 1'b1;
                w_ld_start     = 1'b1;
                w_next         = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Any code other than IDLE, including unknown ones, counts as started.
                if (bus.brew_state != IDLE) begin
                    w_ld_brew = 1'b1;
                    w_next    = S_WAIT_DONE;
                end else if (r_timer <= TMR_W'(1)) begin
                    w_set_err = 1'b1;
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_tick = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (bus.brew_state == EXTRACAO) w_set_saw = 1'b1;
                // An early return to IDLE still ends the cup, but is flagged.
                if (bus.brew_state == IDLE) begin
                    w_set_err = !r_saw_extr;
                    w_next    = S_DONE;
                end else if (r_timer <= TMR_W'(1)) begin
                    w_set_err = 1'b1;
                    w_release = 1'b1;
                    w_next    = S_IDLE;
                end else begin
                    w_tick = 1'b1;
                end
            end
            S_DONE: begin
                bus.done  = r_grant;
                w_serve   = 1'b1;
                w_release = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_timer     <= '0;
            r_saw_extr  <= 1'b0;
            r_error     <= 1'b0;
            r_cups      <= '0;
        end else begin
            if (w_accept) begin
                r_grant     <= w_arb_grant;
                r_grant_idx <= w_arb_idx;
            end
            if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= w_next_ptr;
            end
            if (w_ld_start)     r_timer <= TMR_W'(START_TIMEOUT);
            else if (w_ld_brew) r_timer <= TMR_W'(BREW_TIMEOUT);
            else if (w_tick)    r_timer <= r_timer - 1'b1;
            if (w_ld_brew)      r_saw_extr <= 1'b0;
            else if (w_set_saw) r_saw_extr <= 1'b1;
            if (w_set_err) r_error <= 1'b1;
            if (w_serve && (r_cups != '1)) r_cups <= r_cups + 1'b1;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.error       = r_error;
    assign bus.cups_served = r_cups;

endmodule

// File: tb/tb_cafe_order_scheduler.sv
// Randomized bench for cafe_order_scheduler: the bench plays both the order
// sources and the brewer, and checks against a transaction-level model.
`timescale 1ns/1ps
module tb_cafe_order_scheduler;
    import coffee_pkg::*;

    localparam int N     = 4;
    localparam int ST_TO = 8;
    localparam int BR_TO = 64;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cafe_order_scheduler_if #(.N_REQ(N), .CNT_W(CW)) bus ();

    cafe_order_scheduler #(
        .N_REQ         (N),
        .START_TIMEOUT (ST_TO),
        .BREW_TIMEOUT  (BR_TO),
        .CNT_W         (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_ptr;
    int   m_cups;
    logic m_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec rule: first set request searching upward from the pointer, with wrap.
    function automatic int rr_pick(input logic [N-1:0] mask, input int ptr);
        logic [N-1:0] rot;
        rot = (mask >> ptr) | (mask << (N - ptr));
        for (int i = 0; i < N; i++) if (rot[i]) return (ptr + i) % N;
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.brew_state = IDLE;
        step();
        rst = 1'b0;
        m_ptr = 0; m_cups = 0; m_err = 1'b0;
    endtask

    // kind: 0 normal, 1 first brew with fill path, 2 early return (no 9),
    //       3 brewer ignores start, 4 brewer stuck in MOER, 5 shortest legal brew
    task automatic order(input logic [N-1:0] mask, input int kind);
        int           idx;
        int           cyc;
        int           d;
        int           seq[$];
        int           q[$];
        logic [N-1:0] oh;
        idx = rr_pick(mask, m_ptr);
        oh  = N'(1) << idx;
        bus.req = mask;
        step();
        chk("grant_first", bus.grant, oh);
        chk("brew_start", bus.brew_start, 1);
        chk("busy_start", bus.busy, 1);
        step();
        chk("start_once", bus.brew_start, 0);
        if (kind == 3 || kind == 4) begin
            bus.brew_state = (kind == 4) ? MOER : IDLE;
            cyc = 1;
            while (bus.busy && cyc < 200) begin
                chk("grant_hold", bus.grant, oh);
                step();
                cyc++;
                chk("no_done_wdog", bus.done, 0);
            end
            // 1 START cycle + watchdog span (+1 WAIT_BUSY cycle before a hang)
            chk(kind == 3 ? "wdog_start_cyc" : "wdog_brew_cyc", cyc, kind == 3 ? ST_TO + 1 : BR_TO + 2);
            bus.brew_state = IDLE;
            m_err = 1'b1;
            m_ptr = (idx + 1) % N;
            chk("wdog_err", bus.error, m_err);
            chk("wdog_grant", bus.grant, 0);
            chk("wdog_cups", bus.cups_served, m_cups);
            return;
        end
        case (kind)
            1:       seq = '{2, 3, 4, 3, 5, 6, 7, 8, 9};
            2:       seq = '{2, 3, int'($urandom_range(4, 8))};
            5:       seq = '{2, 9};
            default: seq = '{2, 3, 5, 6, 7, 8, 9};
        endcase
        d = (kind == 5) ? 0 : int'($urandom_range(0, 4));
        for (int i = 0; i < d; i++) q.push_back(1);
        foreach (seq[i]) begin
            int rep;
            rep = (kind == 5) ? 1 : int'($urandom_range(1, 3));
            for (int r = 0; r < rep; r++) q.push_back(seq[i]);
        end
        q.push_back(1);
        foreach (q[j]) begin
            bus.brew_state = 4'(q[j]);
            step();
            if (j == q.size() - 1) begin
                chk("done_pulse", bus.done, oh);
            end else begin
                chk("no_done_early", bus.done, 0);
                chk("grant_hold", bus.grant, oh);
                chk("no_restart", bus.brew_start, 0);
            end
        end
        if (kind == 2) m_err = 1'b1;
        chk("err_at_done", bus.error, m_err);
        bus.req = mask & ~oh;
        step();
        m_cups = (m_cups == CMAX) ? CMAX : m_cups + 1;
        m_ptr  = (idx + 1) % N;
        chk("idle_busy", bus.busy, 0);
        chk("idle_grant", bus.grant, 0);
        chk("done_single", bus.done, 0);
        chk("cups", bus.cups_served, m_cups);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL sim_limit: got still running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.brew_state = IDLE;
        step();
        step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_start", bus.brew_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_cups", bus.cups_served, 0);
        rst = 1'b0;
        m_ptr = 0; m_cups = 0; m_err = 1'b0;
        step();
        chk("idle_no_req", bus.busy, 0);

        order(4'b0001, 1);

        do_reset();
        for (int i = 0; i < 5; i++) order(4'b1111, 0);

        do_reset();
        order(4'b0100, 0);
        order(4'b1001, 0);
        order(4'b1001, 0);

        do_reset();
        order(4'b0011, 3);
        order(4'b0011, 0);
        order(4'b0110, 4);
        order(4'b0110, 2);

        // Reset while the brewer is mid-cycle: everything back to zero, no done.
        bus.req = 4'b0100;
        step();
        step();
        bus.brew_state = LIGAR;
        step();
        bus.brew_state = MOER;
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_grant", bus.grant, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_start", bus.brew_start, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_error", bus.error, 0);
        chk("midrst_cups", bus.cups_served, 0);
        rst = 1'b0;
        bus.req = '0;
        bus.brew_state = IDLE;
        m_ptr = 0; m_cups = 0; m_err = 1'b0;
        step();
        chk("midrst_idle", bus.busy, 0);
        order(4'b1111, 0);

        for (int i = 0; i < 40; i++) begin
            int r;
            int k;
            r = int'($urandom_range(0, 9));
            k = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
            order(N'($urandom_range(1, (1 << N) - 1)), k);
        end

        do_reset();
        for (int i = 0; i < 256; i++) order(N'($urandom_range(1, (1 << N) - 1)), 5);
        chk("cups_saturated", bus.cups_served, 255);
        chk("sat_no_error", bus.error, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
